// File: rtl/bios_loader_pkg.sv
// rtl/bios_loader_pkg.sv - shared types and constants for the BIOS frame loader
//
// Purpose: FSM state encoding, default frame start byte and the byte counts
// of each frame field. The 2-bit byte counter compares against the
// LAST_*_IDX values to find the final byte of a field.
package bios_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_COUNT = 3'd2,
    S_DATA  = 3'd3,
    S_CSUM  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

  localparam int ADDR_BYTES  = 4;
  localparam int COUNT_BYTES = 4;
  localparam int WORD_BYTES  = 4;

  localparam logic [1:0] LAST_ADDR_IDX  = 2'(ADDR_BYTES - 1);
  localparam logic [1:0] LAST_COUNT_IDX = 2'(COUNT_BYTES - 1);
  localparam logic [1:0] LAST_WORD_IDX  = 2'(WORD_BYTES - 1);

endpackage

// File: rtl/bios_loader.sv
// rtl/bios_loader.sv - UART byte-stream frame parser writing into the BIOS memory port
//
// Purpose: parses MAGIC | addr[4] | count[4] | payload[4*N] | checksum frames
// and writes each assembled 32-bit word into the memory port, holding the
// core in reset until a frame completes with a good checksum.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_data    byte from the UART receiver
//   in_valid   in_data is valid
//   in_ready   loader accepts bytes (1 whenever out of reset)
//   mem_we     byte write enables, 4'hF for one cycle per word
//   mem_addr   word address of the write
//   mem_din    write data
//   cpu_rst    core reset request, released only after a good frame
//   load_done  last frame loaded with a good checksum
//   load_err   last frame was rejected
module bios_loader
  import bios_loader_pkg::*;
#(
  parameter int         MEM_ADDR_WIDTH = 12,
  parameter logic [7:0] MAGIC          = MAGIC_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [3:0]                mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]               mem_din,
  output logic                      cpu_rst,
  output logic                      load_done,
  output logic                      load_err
);

  // One past the last word of the memory; frames may end exactly here.
  localparam logic [32:0] W_LIMIT = 33'd1 << MEM_ADDR_WIDTH;

  state_t                    r_state;
  state_t                    w_state_next;

  logic                      r_ready;
  logic [1:0]                r_cnt;
  logic [23:0]               r_shift;
  logic [29:0]               r_base;
  logic [31:0]               r_left;
  logic [MEM_ADDR_WIDTH-1:0] r_waddr;
  logic [7:0]                r_csum;
  logic [3:0]                r_we;
  logic [MEM_ADDR_WIDTH-1:0] r_maddr;
  logic [31:0]               r_mdin;
  logic                      r_cpu_rst;
  logic                      r_done;
  logic                      r_err;

  logic                      w_hs;
  logic                      w_magic;
  logic [31:0]               w_word;
  logic [32:0]               w_span;
  logic                      w_fits;

  assign w_hs    = in_valid & r_ready;
  assign w_magic = w_hs && (in_data == MAGIC);
  // Little-endian assembly: earlier bytes sit in the low lanes of r_shift.
  assign w_word  = {in_data, r_shift};
  // 33-bit end-of-frame word index so a huge count cannot wrap into range.
  assign w_span  = {3'b000, r_base} + {1'b0, w_word};
  assign w_fits  = (w_span <= W_LIMIT);

  assign in_ready  = r_ready;
  assign mem_we    = r_we;
  assign mem_addr  = r_maddr;
  assign mem_din   = r_mdin;
  assign cpu_rst   = r_cpu_rst;
  assign load_done = r_done;
  assign load_err  = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (w_magic) begin
          w_state_next = S_ADDR;
        end
      end
      S_ADDR: begin
        if (w_hs && r_cnt == LAST_ADDR_IDX) begin
          w_state_next = (w_word[1:0] != 2'b00) ? S_ERR : S_COUNT;
        end
      end
      S_COUNT: begin
        if (w_hs && r_cnt == LAST_COUNT_IDX) begin
          if (!w_fits) begin
            w_state_next = S_ERR;
          end else if (w_word == 32'd0) begin
            w_state_next = S_CSUM;
          end else begin
            w_state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_hs && r_cnt == LAST_WORD_IDX && r_left == 32'd1) begin
          w_state_next = S_CSUM;
        end
      end
      S_CSUM: begin
        if (w_hs) begin
          w_state_next = (in_data == r_csum) ? S_DONE : S_ERR;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready   <= 1'b0;
      r_cnt     <= 2'd0;
      r_shift   <= 24'd0;
      r_base    <= 30'd0;
      r_left    <= 32'd0;
      r_waddr   <= '0;
      r_csum    <= 8'd0;
      r_we      <= 4'h0;
      r_maddr   <= '0;
      r_mdin    <= 32'd0;
      r_cpu_rst <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_we    <= 4'h0;
      // Shifting outside the field states is harmless: every field
      // replaces all three held bytes before the word is used.
      if (w_hs) begin
        r_shift <= w_word[31:8];
      end
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (w_magic) begin
            r_cnt     <= 2'd0;
            r_csum    <= 8'd0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cpu_rst <= 1'b1;
          end
        end
        S_ADDR: begin
          if (w_hs) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == LAST_ADDR_IDX) begin
              r_base <= w_word[31:2];
            end
          end
        end
        S_COUNT: begin
          if (w_hs) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == LAST_COUNT_IDX) begin
              r_left  <= w_word;
              r_waddr <= r_base[MEM_ADDR_WIDTH-1:0];
            end
          end
        end
        S_DATA: begin
          if (w_hs) begin
            r_cnt  <= r_cnt + 2'd1;
            r_csum <= r_csum + in_data;
            if (r_cnt == LAST_WORD_IDX) begin
              r_we    <= 4'hF;
              r_maddr <= r_waddr;
              r_mdin  <= w_word;
              r_waddr <= r_waddr + MEM_ADDR_WIDTH'(1);
              r_left  <= r_left - 32'd1;
            end
          end
        end
        default: ;
      endcase
      if (w_state_next == S_DONE && r_state != S_DONE) begin
        r_done    <= 1'b1;
        r_cpu_rst <= 1'b0;
      end
      if (w_state_next == S_ERR && r_state != S_ERR) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
